multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control FSM that sequences a shared RV32I datapath over multiple cycles: one ALU, one unified instruction/data memory port with ready handshake, instruction register, ALUOut/MDR holding registers. It replaces the single-cycle opcode decoder when the core moves to the multicycle datapath. It issues per-state datapath enables, mux selects and memory requests, and stalls on memory wait states.

## Interface
- No parameters.
- clk_i  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- instr_op_i  in  7  opcode from instruction register, bits [6:0]
- zero_i  in  1  ALU Z flag, NZCV[2]
- mem_ready_i  in  1  memory completes current request this cycle
- pc_write_o  out  1  load PC
- old_pc_write_o  out  1  capture current PC into OldPC
- ir_write_o  out  1  load instruction register
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  request is a write
- iord_o  out  1  memory address: 0 = PC, 1 = ALUOut
- reg_write_o  out  1  register-file write
- mem_to_reg_o  out  2  write-back: 00 ALUOut, 01 MDR, 10 PC (already PC+4)
- alu_src_a_o  out  2  00 rs1, 01 PC, 10 OldPC
- alu_src_b_o  out  2  00 rs2, 01 constant 4, 10 immediate
- alu_op_o  out  2  00 add, 01 subtract, 10 decode funct
- pc_source_o  out  2  00 ALU result, 01 ALUOut, 10 ALU result & ~1
- illegal_o  out  1  sticky unsupported-opcode flag
- state_o  out  4  current state encoding, for debug

## Operation
- States, with encoding and outputs:
  - FETCH(0): mem_req, iord=0, alu_src_a=01, alu_src_b=01, alu_op=00, pc_source=00, old_pc_write=1.
    - When mem_ready_i: also ir_write=1 and pc_write=1, then go to DECODE.
    - Otherwise hold, with pc_write=0 and ir_write=0.
  - DECODE(1): alu_src_a=10, alu_src_b=10, alu_op=00. ALUOut latches OldPC+imm. Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 and 0100011 → ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - any other → TRAP
  - EXEC_R(2): src_a=00, src_b=00, alu_op=10 → WB_ALU.
  - EXEC_I(3): src_a=00, src_b=10, alu_op=10 → WB_ALU.
  - ADDR(4): src_a=00, src_b=10, alu_op=00. Goes to MEM_RD for a load, MEM_WR for a store.
  - MEM_RD(5): mem_req, iord=1, we=0. Hold until mem_ready_i; MDR loads on mem_ready_i, then WB_MEM.
  - MEM_WR(6): mem_req, iord=1, we=1. Hold until mem_ready_i, then FETCH.
  - WB_ALU(7): reg_write, mem_to_reg=00 → FETCH.
  - WB_MEM(8): reg_write, mem_to_reg=01 → FETCH.
  - BRANCH(9): src_a=00, src_b=00, alu_op=01, pc_source=01, pc_write = zero_i (Mealy term) → FETCH. BEQ only.
  - JAL(10): reg_write, mem_to_reg=10, pc_source=01, pc_write → FETCH.
  - JALR(11): reg_write, mem_to_reg=10, src_a=00, src_b=10, alu_op=00, pc_source=10, pc_write → FETCH.
  - TRAP(12): all enables 0, illegal_o=1. Terminal until reset.
- Outputs not listed for a state are 0.
- Encodings 13–15 are unreachable. If reached, the FSM goes to TRAP next cycle.

## Timing
- Reset: state=FETCH, illegal_o=0.
  - While rst_n low, every enable output (pc_write, old_pc_write, ir_write, mem_req, mem_we, reg_write) is forced to 0.
  - Selects are 0; state_o=0.
- Reset assertion mid-instruction aborts it immediately. Any partial memory request is dropped and no register or PC write occurs.
- First mem_req_o is in the first clock after rst_n deasserts.
- Latencies with zero-wait memory (mem_ready_i=1 on request cycle):
  - R/I-type 4 cycles; load 5; store 4; branch, JAL and JALR 3.
  - Each memory wait cycle adds one cycle.
- mem_req_o, mem_we_o and iord_o stay stable while waiting. The request is complete on the cycle mem_ready_i=1.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.
- JALR links correctly because the PC register already holds PC+4 from FETCH, and the new PC is written at the end of the JALR cycle.

## Structure
- Shared package multicycle_pkg holds:
  - state localparams (4-bit)
  - opcode constants
  - ALUop, alu_src_a/b, pc_source and mem_to_reg codes
- The ALU controller reuses the same ALUop codes.
- One natural sub-module: multicycle_ctrl_decode, a combinational state-to-output decoder. The parent keeps the state register, next-state logic and the sticky illegal flag.

## Test plan
- Reset, then R-type (0110011) with mem_ready_i tied 1:
  - state sequence 0,1,2,7,0
  - pc_write once in FETCH
  - reg_write only in cycle 4
- Load (0000011) with mem_ready_i low 2 cycles in MEM_RD:
  - sequence 0,1,4,5,5,5,8
  - iord=1 and mem_req held for 3 cycles
  - total 7 cycles
- Store (0100011): MEM_WR asserts mem_we=1 with iord=1. reg_write is never asserted, and the FSM returns to FETCH.
- Branch (1100011), twice:
  - zero_i=1: pc_write=1 with pc_source=01.
  - zero_i=0: pc_write=0.
  - Both cases take 3 cycles.
- Opcode 0000000:
  - enters TRAP; illegal_o=1; mem_req stays 0 for 10 cycles.
  - After a reset pulse, illegal_o=0 and state=FETCH.
- Reset asserted during MEM_WR wait:
  - all enables drop to 0 immediately
  - after release, the first cycle is FETCH with iord=0

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, opcodes,
// datapath select codes and the bundled control-word type.
package multicycle_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC_R = 4'd2;
  localparam logic [3:0] ST_EXEC_I = 4'd3;
  localparam logic [3:0] ST_ADDR   = 4'd4;
  localparam logic [3:0] ST_MEM_RD = 4'd5;
  localparam logic [3:0] ST_MEM_WR = 4'd6;
  localparam logic [3:0] ST_WB_ALU = 4'd7;
  localparam logic [3:0] ST_WB_MEM = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_JAL    = 4'd10;
  localparam logic [3:0] ST_JALR   = 4'd11;
  localparam logic [3:0] ST_TRAP   = 4'd12;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALUop codes are also consumed by the ALU controller
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_RS1   = 2'b00;
  localparam logic [1:0] SRC_A_PC    = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       old_pc_write;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic [3:0] decode_next(input logic [6:0] op);
    case (op)
      OP_RTYPE:          decode_next = ST_EXEC_R;
      OP_ITYPE:          decode_next = ST_EXEC_I;
      OP_LOAD, OP_STORE: decode_next = ST_ADDR;
      OP_BRANCH:         decode_next = ST_BRANCH;
      OP_JAL:            decode_next = ST_JAL;
      OP_JALR:           decode_next = ST_JALR;
      default:           decode_next = ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control-word decoder; the only Mealy terms are the
// FETCH completion writes and the BEQ PC write.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_req      = 1'b1;
        o_ctrl.old_pc_write = 1'b1;
        o_ctrl.alu_src_a    = SRC_A_PC;
        o_ctrl.alu_src_b    = SRC_B_FOUR;
        o_ctrl.alu_op       = ALU_ADD;
        o_ctrl.pc_source    = PC_SRC_ALU;
        o_ctrl.ir_write     = i_mem_ready;
        o_ctrl.pc_write     = i_mem_ready;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_a = SRC_A_OLDPC;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      ST_EXEC_R: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_RS2;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      ST_EXEC_I: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      ST_ADDR: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      ST_MEM_WR: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
        o_ctrl.mem_we  = 1'b1;
      end
      ST_WB_ALU: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = WB_ALUOUT;
      end
      ST_WB_MEM: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = WB_MDR;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_RS2;
        o_ctrl.alu_op    = ALU_SUB;
        o_ctrl.pc_source = PC_SRC_ALUOUT;
        o_ctrl.pc_write  = i_zero;
      end
      ST_JAL: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = WB_PC;
        o_ctrl.pc_source  = PC_SRC_ALUOUT;
        o_ctrl.pc_write   = 1'b1;
      end
      ST_JALR: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = WB_PC;
        o_ctrl.alu_src_a  = SRC_A_RS1;
        o_ctrl.alu_src_b  = SRC_B_IMM;
        o_ctrl.alu_op     = ALU_ADD;
        o_ctrl.pc_source  = PC_SRC_JALR;
        o_ctrl.pc_write   = 1'b1;
      end
      default: o_ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: state register, next-state logic, sticky
// illegal-opcode flag, and reset gating of the decoded control word.
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [6:0] instr_op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       old_pc_write_o,
  output logic       ir_write_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       r_illegal;
  ctrl_t      w_ctrl;
  ctrl_t      w_ctrl_out;

  always_comb begin
    w_next_state = ST_TRAP;
    case (r_state)
      ST_FETCH:  w_next_state = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: w_next_state = decode_next(instr_op_i);
      ST_EXEC_R,
      ST_EXEC_I: w_next_state = ST_WB_ALU;
      ST_ADDR:   w_next_state = (instr_op_i == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: w_next_state = mem_ready_i ? ST_WB_MEM : ST_MEM_RD;
      ST_MEM_WR: w_next_state = mem_ready_i ? ST_FETCH : ST_MEM_WR;
      ST_WB_ALU,
      ST_WB_MEM,
      ST_BRANCH,
      ST_JAL,
      ST_JALR:   w_next_state = ST_FETCH;
      default:   w_next_state = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == ST_TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  multicycle_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready_i),
    .i_zero      (zero_i),
    .o_ctrl      (w_ctrl)
  );

  // Reset resets to FETCH, whose word requests memory; mask it while held
  assign w_ctrl_out = rst_n ? w_ctrl : CTRL_IDLE;

  assign pc_write_o     = w_ctrl_out.pc_write;
  assign old_pc_write_o = w_ctrl_out.old_pc_write;
  assign ir_write_o     = w_ctrl_out.ir_write;
  assign mem_req_o      = w_ctrl_out.mem_req;
  assign mem_we_o       = w_ctrl_out.mem_we;
  assign iord_o         = w_ctrl_out.iord;
  assign reg_write_o    = w_ctrl_out.reg_write;
  assign mem_to_reg_o   = w_ctrl_out.mem_to_reg;
  assign alu_src_a_o    = w_ctrl_out.alu_src_a;
  assign alu_src_b_o    = w_ctrl_out.alu_src_b;
  assign alu_op_o       = w_ctrl_out.alu_op;
  assign pc_source_o    = w_ctrl_out.pc_source;
  assign illegal_o      = r_illegal;
  assign state_o        = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: one task per scenario,
// hand-computed expected sequences per cycle.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic [6:0] instr_op_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, old_pc_write_o, ir_write_o, mem_req_o, mem_we_o, iord_o;
  logic       reg_write_o, illegal_o;
  logic [1:0] mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .instr_op_i     (instr_op_i),
    .zero_i         (zero_i),
    .mem_ready_i    (mem_ready_i),
    .pc_write_o     (pc_write_o),
    .old_pc_write_o (old_pc_write_o),
    .ir_write_o     (ir_write_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .iord_o         (iord_o),
    .reg_write_o    (reg_write_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_o       (alu_op_o),
    .pc_source_o    (pc_source_o),
    .illegal_o      (illegal_o),
    .state_o        (state_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    mem_ready_i = 1'b1;
    zero_i      = 1'b1;
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_state got %0d exp 0", state_o); end
    checks++; if ({pc_write_o, old_pc_write_o, ir_write_o, mem_req_o, mem_we_o, reg_write_o} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_enables got %b exp 000000", {pc_write_o, old_pc_write_o, ir_write_o, mem_req_o, mem_we_o, reg_write_o});
    end
    checks++; if ({alu_src_a_o, alu_src_b_o, pc_source_o, iord_o} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_selects got %b exp 0000000", {alu_src_a_o, alu_src_b_o, pc_source_o, iord_o});
    end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got %b exp 0", illegal_o); end
    rst_n  = 1'b1;
    zero_i = 1'b0;
    #1;
    checks++; if ({mem_req_o, old_pc_write_o, pc_write_o, iord_o} !== 4'b1110) begin
      errors++; $display("[TB] FAIL first_fetch got %b exp 1110", {mem_req_o, old_pc_write_o, pc_write_o, iord_o});
    end
  endtask

  task automatic test_r_type;
    logic [3:0] es [4];
    logic       epw [4];
    logic       erw [4];
    es = '{4'd0, 4'd1, 4'd2, 4'd7};
    epw = '{1'b1, 1'b0, 1'b0, 1'b0};
    erw = '{1'b0, 1'b0, 1'b0, 1'b1};
    instr_op_i  = 7'b0110011;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state_o !== es[i]) begin errors++; $display("[TB] FAIL rtype_state cyc%0d got %0d exp %0d", i, state_o, es[i]); end
      checks++; if (pc_write_o !== epw[i]) begin errors++; $display("[TB] FAIL rtype_pc_write cyc%0d got %b exp %b", i, pc_write_o, epw[i]); end
      checks++; if (reg_write_o !== erw[i]) begin errors++; $display("[TB] FAIL rtype_reg_write cyc%0d got %b exp %b", i, reg_write_o, erw[i]); end
      if (i == 1) begin
        checks++; if ({alu_src_a_o, alu_src_b_o} !== 4'b1010) begin errors++; $display("[TB] FAIL decode_srcs got %b exp 1010", {alu_src_a_o, alu_src_b_o}); end
      end
      if (i == 2) begin
        checks++; if ({alu_src_a_o, alu_src_b_o, alu_op_o} !== 6'b000010) begin errors++; $display("[TB] FAIL execr_alu got %b exp 000010", {alu_src_a_o, alu_src_b_o, alu_op_o}); end
      end
      tick();
    end
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("[TB] FAIL rtype_return got %0d exp 0", state_o); end
  endtask

  task automatic test_i_type;
    logic [3:0] es [4];
    es = '{4'd0, 4'd1, 4'd3, 4'd7};
    instr_op_i  = 7'b0010011;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state_o !== es[i]) begin errors++; $display("[TB] FAIL itype_state cyc%0d got %0d exp %0d", i, state_o, es[i]); end
      if (i == 2) begin
        checks++; if ({alu_src_a_o, alu_src_b_o, alu_op_o} !== 6'b001010) begin errors++; $display("[TB] FAIL execi_alu got %b exp 001010", {alu_src_a_o, alu_src_b_o, alu_op_o}); end
      end
      tick();
    end
  endtask

  task automatic test_load;
    logic [3:0] es [7];
    logic       rdy [7];
    logic       ereq [7];
    logic       eio [7];
    es   = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd8};
    rdy  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ereq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    eio  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    instr_op_i = 7'b0000011;
    for (int i = 0; i < 7; i++) begin
      mem_ready_i = rdy[i];
      #1;
      checks++; if (state_o !== es[i]) begin errors++; $display("[TB] FAIL load_state cyc%0d got %0d exp %0d", i, state_o, es[i]); end
      checks++; if ({mem_req_o, iord_o} !== {ereq[i], eio[i]}) begin
        errors++; $display("[TB] FAIL load_req_iord cyc%0d got %b%b exp %b%b", i, mem_req_o, iord_o, ereq[i], eio[i]);
      end
      if (i == 6) begin
        checks++; if ({reg_write_o, mem_to_reg_o} !== 3'b101) begin errors++; $display("[TB] FAIL load_wb got %b exp 101", {reg_write_o, mem_to_reg_o}); end
      end
      tick();
    end
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("[TB] FAIL load_return got %0d exp 0", state_o); end
  endtask

  task automatic test_store;
    logic [3:0] es [5];
    logic       rdy [5];
    logic       ewe [5];
    es  = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd6};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ewe = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    instr_op_i = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready_i = rdy[i];
      #1;
      checks++; if (state_o !== es[i]) begin errors++; $display("[TB] FAIL store_state cyc%0d got %0d exp %0d", i, state_o, es[i]); end
      checks++; if ({mem_we_o, reg_write_o} !== {ewe[i], 1'b0}) begin
        errors++; $display("[TB] FAIL store_we_rw cyc%0d got %b%b exp %b0", i, mem_we_o, reg_write_o, ewe[i]);
      end
      if (i >= 3) begin
        checks++; if ({mem_req_o, iord_o} !== 2'b11) begin errors++; $display("[TB] FAIL store_req_iord cyc%0d got %b%b exp 11", i, mem_req_o, iord_o); end
      end
      tick();
    end
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("[TB] FAIL store_return got %0d exp 0", state_o); end
  endtask

  task automatic test_branch;
    logic [3:0] es [3];
    es = '{4'd0, 4'd1, 4'd9};
    instr_op_i  = 7'b1100011;
    mem_ready_i = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      for (int i = 0; i < 3; i++) begin
        zero_i = (i == 2) ? z[0] : ~z[0];
        #1;
        checks++; if (state_o !== es[i]) begin errors++; $display("[TB] FAIL branch_state z%0d cyc%0d got %0d exp %0d", z, i, state_o, es[i]); end
        if (i == 2) begin
          checks++; if (pc_write_o !== z[0]) begin errors++; $display("[TB] FAIL branch_pc_write z%0d got %b exp %b", z, pc_write_o, z[0]); end
          checks++; if ({pc_source_o, alu_op_o} !== 4'b0101) begin errors++; $display("[TB] FAIL branch_sel z%0d got %b exp 0101", z, {pc_source_o, alu_op_o}); end
        end
        tick();
      end
      #1;
      checks++; if (state_o !== 4'd0) begin errors++; $display("[TB] FAIL branch_return z%0d got %0d exp 0", z, state_o); end
    end
    zero_i = 1'b0;
  endtask

  task automatic test_jumps;
    logic [6:0] ops  [2];
    logic [3:0] est  [2];
    logic [1:0] epcs [2];
    logic [1:0] esb  [2];
    ops  = '{7'b1101111, 7'b1100111};
    est  = '{4'd10, 4'd11};
    epcs = '{2'b01, 2'b10};
    esb  = '{2'b00, 2'b10};
    mem_ready_i = 1'b1;
    for (int j = 0; j < 2; j++) begin
      instr_op_i = ops[j];
      tick();
      tick();
      #1;
      checks++; if (state_o !== est[j]) begin errors++; $display("[TB] FAIL jump%0d_state got %0d exp %0d", j, state_o, est[j]); end
      checks++; if ({pc_write_o, reg_write_o, mem_to_reg_o, pc_source_o, alu_src_b_o} !== {2'b11, 2'b10, epcs[j], esb[j]}) begin
        errors++; $display("[TB] FAIL jump%0d_ctrl got %b exp %b", j, {pc_write_o, reg_write_o, mem_to_reg_o, pc_source_o, alu_src_b_o}, {2'b11, 2'b10, epcs[j], esb[j]});
      end
      tick();
      #1;
      checks++; if (state_o !== 4'd0) begin errors++; $display("[TB] FAIL jump%0d_return got %0d exp 0", j, state_o); end
    end
  endtask

  task automatic test_trap;
    instr_op_i  = 7'b0000000;
    mem_ready_i = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (state_o !== 4'd12) begin errors++; $display("[TB] FAIL trap_state got %0d exp 12", state_o); end
    checks++; if (illegal_o !== 1'b1) begin errors++; $display("[TB] FAIL trap_illegal got %b exp 1", illegal_o); end
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      checks++; if ({mem_req_o, pc_write_o, reg_write_o, state_o} !== {3'b000, 4'd12}) begin
        errors++; $display("[TB] FAIL trap_hold cyc%0d got req%b pcw%b rw%b st%0d exp req0 pcw0 rw0 st12", i, mem_req_o, pc_write_o, reg_write_o, state_o);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({illegal_o, state_o, mem_req_o} !== 6'b0) begin errors++; $display("[TB] FAIL trap_reset got ill%b st%0d req%b exp 0 0 0", illegal_o, state_o, mem_req_o); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if ({illegal_o, state_o, mem_req_o} !== 6'b000001) begin errors++; $display("[TB] FAIL trap_release got ill%b st%0d req%b exp 0 0 1", illegal_o, state_o, mem_req_o); end
  endtask

  task automatic test_reset_mid_store;
    logic rdy [3];
    rdy = '{1'b1, 1'b0, 1'b0};
    instr_op_i = 7'b0100011;
    for (int i = 0; i < 3; i++) begin
      mem_ready_i = rdy[i];
      #1;
      tick();
    end
    mem_ready_i = 1'b0;
    #1;
    checks++; if ({state_o, mem_req_o, mem_we_o, iord_o} !== {4'd6, 3'b111}) begin
      errors++; $display("[TB] FAIL midwr_wait got st%0d %b%b%b exp st6 111", state_o, mem_req_o, mem_we_o, iord_o);
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({pc_write_o, old_pc_write_o, ir_write_o, mem_req_o, mem_we_o, reg_write_o, iord_o} !== 7'b0) begin
      errors++; $display("[TB] FAIL midwr_abort got %b exp 0000000", {pc_write_o, old_pc_write_o, ir_write_o, mem_req_o, mem_we_o, reg_write_o, iord_o});
    end
    checks++; if (state_o !== 4'd0) begin errors++; $display("[TB] FAIL midwr_state got %0d exp 0", state_o); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if ({state_o, mem_req_o, mem_we_o, iord_o} !== {4'd0, 3'b100}) begin
      errors++; $display("[TB] FAIL midwr_release got st%0d %b%b%b exp st0 100", state_o, mem_req_o, mem_we_o, iord_o);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_op_i  = 7'b0;
    zero_i      = 1'b0;
    mem_ready_i = 1'b0;
    test_reset();
    test_r_type();
    test_i_type();
    test_load();
    test_store();
    test_branch();
    test_jumps();
    test_trap();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
